// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//
// Registered output stage placed directly after the ALU result select mux.
// It captures the selected result together with its op select and the
// carry/overflow side-bands. Zero and negative flags are derived when an entry
// is loaded, not at the output. The result is presented downstream through a
// valid/ready handshake. A 2-entry skid buffer (main + skid) lets in_ready be a
// pure register output without adding a bubble when streaming. The stage also
// counts completed output transfers.
//
// Ports:
//   clk           clock, rising edge
//   rstb          asynchronous active-low reset
//   in_valid      upstream result valid
//   in_ready      stage can accept a result this cycle (registered)
//   in_result     selected ALU result (WIDTH bits)
//   in_sel        op select that produced in_result
//   in_carry      carry-out side-band
//   in_overflow   signed-overflow side-band
//   out_valid     registered result available
//   out_ready     consumer accepts result
//   out_result    registered result
//   out_sel       registered op select
//   out_zero      1 when out_result == 0
//   out_negative  out_result[WIDTH-1]
//   out_carry     registered carry
//   out_overflow  registered overflow
//   xfer_count    completed output transfers, wraps modulo 2^COUNT_WIDTH
// -----------------------------------------------------------------------------
module alu_result_stage #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_result,
    input  logic [2:0]             in_sel,
    input  logic                   in_carry,
    input  logic                   in_overflow,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_result,
    output logic [2:0]             out_sel,
    output logic                   out_zero,
    output logic                   out_negative,
    output logic                   out_carry,
    output logic                   out_overflow,
    output logic [COUNT_WIDTH-1:0] xfer_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [2:0]       sel;
        logic             zero;
        logic             negative;
        logic             carry;
        logic             overflow;
    } entry_t;

    state_t                 state;
    entry_t                 main_q;
    entry_t                 skid_q;
    entry_t                 in_entry;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   push;
    logic                   pop;

    // Flags are derived from the incoming result so the output side only
    // ever sees registered values.
    always_comb begin
        in_entry          = '0;
        in_entry.result   = in_result;
        in_entry.sel      = in_sel;
        in_entry.zero     = (in_result == '0);
        in_entry.negative = in_result[WIDTH-1];
        in_entry.carry    = in_carry;
        in_entry.overflow = in_overflow;
    end

    always_comb begin
        push = in_valid & in_ready_q;
        pop  = out_valid_q & out_ready;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state       <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        main_q      <= in_entry;
                        state       <= ONE;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        skid_q      <= in_entry;
                        state       <= FULL;
                        in_ready_q  <= 1'b0;
                    end else if (pop && !push) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end else if (push && pop) begin
                        // Streaming: replace the departing entry in place.
                        main_q      <= in_entry;
                    end
                end
                FULL: begin
                    // in_ready is low here, so no push can arrive.
                    if (pop) begin
                        main_q      <= skid_q;
                        state       <= ONE;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase

            if (pop) begin
                count_q <= count_q + COUNT_WIDTH'(1);
            end
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_result   = main_q.result;
    assign out_sel      = main_q.sel;
    assign out_zero     = main_q.zero;
    assign out_negative = main_q.negative;
    assign out_carry    = main_q.carry;
    assign out_overflow = main_q.overflow;
    assign xfer_count   = count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_result_stage
//
// Directed bench for alu_result_stage. A default-sized instance covers the
// handshake, flags, ordering and reset; a second instance with a 4-bit counter
// covers counter wrap-around. Inputs change 1 ns after the rising edge and
// outputs are sampled at the same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_alu_result_stage;

    logic        clk;
    logic        rstb;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [2:0]  in_sel;
    logic        in_carry;
    logic        in_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_sel;
    logic        out_zero;
    logic        out_negative;
    logic        out_carry;
    logic        out_overflow;
    logic [15:0] xfer_count;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_in_result;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_out_result;
    logic [2:0]  s_out_sel;
    logic        s_out_zero;
    logic        s_out_negative;
    logic        s_out_carry;
    logic        s_out_overflow;
    logic [3:0]  s_xfer_count;

    int tests;
    int failed;
    int exp_count;

    alu_result_stage #(
        .WIDTH       (32),
        .COUNT_WIDTH (16)
    ) dut (
        .clk          (clk),
        .rstb         (rstb),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_sel       (in_sel),
        .in_carry     (in_carry),
        .in_overflow  (in_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_sel      (out_sel),
        .out_zero     (out_zero),
        .out_negative (out_negative),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .xfer_count   (xfer_count)
    );

    alu_result_stage #(
        .WIDTH       (8),
        .COUNT_WIDTH (4)
    ) dut_small (
        .clk          (clk),
        .rstb         (rstb),
        .in_valid     (s_in_valid),
        .in_ready     (s_in_ready),
        .in_result    (s_in_result),
        .in_sel       (3'd1),
        .in_carry     (1'b0),
        .in_overflow  (1'b0),
        .out_valid    (s_out_valid),
        .out_ready    (s_out_ready),
        .out_result   (s_out_result),
        .out_sel      (s_out_sel),
        .out_zero     (s_out_zero),
        .out_negative (s_out_negative),
        .out_carry    (s_out_carry),
        .out_overflow (s_out_overflow),
        .xfer_count   (s_xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstb        = 1'b0;
        in_valid    = 1'b1;
        in_result   = 32'hDEAD_BEEF;
        in_sel      = 3'd7;
        in_carry    = 1'b1;
        in_overflow = 1'b1;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_in_result = 8'h00;
        s_out_ready = 1'b0;
        step();
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            failed++; $display("FAIL reset_out_valid got %0b want 0", out_valid);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            failed++; $display("FAIL reset_in_ready got %0b want 1", in_ready);
        end
        tests++;
        if ({out_result, out_sel, out_zero, out_negative, out_carry, out_overflow} !== 39'd0) begin
            failed++; $display("FAIL reset_outputs got %h/%0d/%b%b%b%b want all zero",
                               out_result, out_sel, out_zero, out_negative, out_carry, out_overflow);
        end
        tests++;
        if (xfer_count !== 16'd0) begin
            failed++; $display("FAIL reset_count got %0d want 0", xfer_count);
        end
        in_valid = 1'b0;
        rstb     = 1'b1;
        step();
        exp_count = 0;
    endtask

    task automatic test_pass_through();
        in_valid    = 1'b1;
        in_result   = 32'h0000_0000;
        in_sel      = 3'd5;
        in_carry    = 1'b1;
        in_overflow = 1'b0;
        out_ready   = 1'b1;
        step();
        in_valid = 1'b0;
        tests++;
        if ({out_valid, out_zero, out_negative, out_sel, out_carry, out_overflow} !== {1'b1, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0}) begin
            failed++; $display("FAIL pass_flags got v=%0b z=%0b n=%0b sel=%0d c=%0b o=%0b want v=1 z=1 n=0 sel=5 c=1 o=0",
                               out_valid, out_zero, out_negative, out_sel, out_carry, out_overflow);
        end
        tests++;
        if (out_result !== 32'h0) begin
            failed++; $display("FAIL pass_result got %h want 00000000", out_result);
        end
        step();
        exp_count++;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failed++; $display("FAIL pass_drain got v=%0b rdy=%0b want v=0 rdy=1", out_valid, in_ready);
        end
        tests++;
        if (xfer_count !== 16'(exp_count)) begin
            failed++; $display("FAIL pass_count got %0d want %0d", xfer_count, exp_count);
        end
    endtask

    task automatic test_backpressure();
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_result   = 32'h8000_0001;
        in_sel      = 3'd2;
        in_carry    = 1'b0;
        in_overflow = 1'b1;
        step();
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_result !== 32'h8000_0001 || out_negative !== 1'b1) begin
            failed++; $display("FAIL bp_first got v=%0b rdy=%0b res=%h neg=%0b want v=1 rdy=1 res=80000001 neg=1",
                               out_valid, in_ready, out_result, out_negative);
        end
        in_result   = 32'h0000_0007;
        in_sel      = 3'd3;
        in_carry    = 1'b1;
        in_overflow = 1'b0;
        step();
        tests++;
        if (in_ready !== 1'b0 || out_result !== 32'h8000_0001 || out_sel !== 3'd2 || out_overflow !== 1'b1 || out_carry !== 1'b0) begin
            failed++; $display("FAIL bp_full got rdy=%0b res=%h sel=%0d o=%0b c=%0b want rdy=0 res=80000001 sel=2 o=1 c=0",
                               in_ready, out_result, out_sel, out_overflow, out_carry);
        end
        // Third value is offered but must be held off while full.
        in_result   = 32'h0000_0009;
        in_sel      = 3'd4;
        in_carry    = 1'b0;
        in_overflow = 1'b0;
        step();
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'h8000_0001 || out_negative !== 1'b1) begin
            failed++; $display("FAIL bp_hold got rdy=%0b v=%0b res=%h neg=%0b want rdy=0 v=1 res=80000001 neg=1",
                               in_ready, out_valid, out_result, out_negative);
        end
        out_ready = 1'b1;
        step();
        exp_count++;
        tests++;
        if (out_result !== 32'h0000_0007 || out_sel !== 3'd3 || out_carry !== 1'b1 || out_negative !== 1'b0 || in_ready !== 1'b1) begin
            failed++; $display("FAIL bp_second got res=%h sel=%0d c=%0b neg=%0b rdy=%0b want res=00000007 sel=3 c=1 neg=0 rdy=1",
                               out_result, out_sel, out_carry, out_negative, in_ready);
        end
        step();
        exp_count++;
        in_valid = 1'b0;
        tests++;
        if (out_result !== 32'h0000_0009 || out_sel !== 3'd4 || out_valid !== 1'b1) begin
            failed++; $display("FAIL bp_third got res=%h sel=%0d v=%0b want res=00000009 sel=4 v=1",
                               out_result, out_sel, out_valid);
        end
        step();
        exp_count++;
        tests++;
        if (out_valid !== 1'b0 || xfer_count !== 16'(exp_count)) begin
            failed++; $display("FAIL bp_count got v=%0b cnt=%0d want v=0 cnt=%0d", out_valid, xfer_count, exp_count);
        end
    endtask

    task automatic test_streaming();
        int errs;
        errs        = 0;
        out_ready   = 1'b1;
        in_sel      = 3'd0;
        in_carry    = 1'b0;
        in_overflow = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            in_valid  = 1'b1;
            in_result = 32'(i);
            step();
            if (i > 1) exp_count++;
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_result !== 32'(i)) begin
                failed++; errs++;
                if (errs <= 5)
                    $display("FAIL stream_%0d got v=%0b rdy=%0b res=%0d want v=1 rdy=1 res=%0d",
                             i, out_valid, in_ready, out_result, i);
            end
        end
        in_valid = 1'b0;
        step();
        exp_count++;
        tests++;
        if (out_valid !== 1'b0 || xfer_count !== 16'(exp_count)) begin
            failed++; $display("FAIL stream_count got v=%0b cnt=%0d want v=0 cnt=%0d", out_valid, xfer_count, exp_count);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_result = 32'hA;
        step();
        tests++;
        if (out_result !== 32'hA || out_valid !== 1'b1) begin
            failed++; $display("FAIL b2b_first got res=%h v=%0b want res=0000000a v=1", out_result, out_valid);
        end
        in_result = 32'hB;
        out_ready = 1'b1;
        step();
        exp_count++;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tests++;
        if (out_result !== 32'hB || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            failed++; $display("FAIL b2b_swap got res=%h v=%0b rdy=%0b want res=0000000b v=1 rdy=1",
                               out_result, out_valid, in_ready);
        end
        out_ready = 1'b1;
        step();
        exp_count++;
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || xfer_count !== 16'(exp_count)) begin
            failed++; $display("FAIL b2b_count got v=%0b cnt=%0d want v=0 cnt=%0d", out_valid, xfer_count, exp_count);
        end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_result = 32'h1111_1111;
        step();
        in_result = 32'h2222_2222;
        step();
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failed++; $display("FAIL rstfull_setup got rdy=%0b v=%0b want rdy=0 v=1", in_ready, out_valid);
        end
        // Asynchronous: effect must be visible before any clock edge.
        #2;
        rstb = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0 || xfer_count !== 16'd0) begin
            failed++; $display("FAIL rstfull_async got v=%0b rdy=%0b res=%h cnt=%0d want v=0 rdy=1 res=0 cnt=0",
                               out_valid, in_ready, out_result, xfer_count);
        end
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            failed++; $display("FAIL rstfull_ignore got v=%0b want 0", out_valid);
        end
        // Push offered across deassertion lands on the next edge.
        in_result = 32'h3333_3333;
        rstb      = 1'b1;
        tests++;
        if (out_valid !== 1'b0) begin
            failed++; $display("FAIL rstfull_release got v=%0b want 0", out_valid);
        end
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_result !== 32'h3333_3333) begin
            failed++; $display("FAIL rstfull_push got v=%0b res=%h want v=1 res=33333333", out_valid, out_result);
        end
        out_ready = 1'b1;
        step();
        tests++;
        if (out_valid !== 1'b0 || xfer_count !== 16'd1) begin
            failed++; $display("FAIL rstfull_count got v=%0b cnt=%0d want v=0 cnt=1", out_valid, xfer_count);
        end
    endtask

    task automatic test_counter_wrap();
        s_out_ready = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            s_in_valid  = 1'b1;
            s_in_result = 8'(i);
            step();
        end
        s_in_valid = 1'b0;
        step();
        tests++;
        if (s_xfer_count !== 4'd1 || s_out_valid !== 1'b0) begin
            failed++; $display("FAIL wrap_count got cnt=%0d v=%0b want cnt=1 v=0", s_xfer_count, s_out_valid);
        end
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        exp_count = 0;
        test_reset();
        test_pass_through();
        test_backpressure();
        test_streaming();
        test_back_to_back();
        test_reset_full();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the ALU result select mux.
- Captures the selected WIDTH-bit result with its op select and carry/overflow side-bands, and derives zero/negative flags at capture time.
- Presents the result to the consumer through a valid/ready handshake, backed by a 2-entry skid buffer so that in_ready is a pure register output.
- Counts completed output transfers.

Parameters:
- WIDTH, 32, data width of result path (matches upstream mux width)
- COUNT_WIDTH, 16, width of output-transfer counter

Ports:
- clk  input  1  single clock, rising edge
- rstb  input  1  asynchronous active-low reset
- in_valid  input  1  upstream result valid
- in_ready  output  1  stage can accept a result this cycle (registered)
- in_result  input  WIDTH  selected ALU result from mux
- in_sel  input  3  op select that produced in_result
- in_carry  input  1  carry-out side-band
- in_overflow  input  1  signed-overflow side-band
- out_valid  output  1  registered result available
- out_ready  input  1  consumer accepts result
- out_result  output  WIDTH  registered result
- out_sel  output  3  registered op select
- out_zero  output  1  1 when out_result == 0
- out_negative  output  1  out_result[WIDTH-1]
- out_carry  output  1  registered carry
- out_overflow  output  1  registered overflow
- xfer_count  output  COUNT_WIDTH  number of completed output transfers, wraps modulo 2^COUNT_WIDTH

Behaviour:
- Reset (rstb low, asynchronous, any cycle):
  - state EMPTY; out_valid=0; in_ready=1.
  - out_result, out_sel and all flags = 0; xfer_count=0.
  - Skid contents cleared; any in-flight data is discarded.
  - in_valid is ignored while rstb is low.
- Handshake events:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Entries:
  - Main register drives the out_* ports.
  - Skid register holds the second entry.
  - Flags are computed from in_result when the entry is loaded, not at output.
- State machine (EMPTY, ONE, FULL):
  - EMPTY: push -> ONE, main loads input. Otherwise stay.
  - ONE, push & !pop -> FULL, skid loads input.
  - ONE, pop & !push -> EMPTY.
  - ONE, push & pop -> ONE, main loads input (back-to-back streaming, no bubble).
  - ONE, neither -> hold.
  - FULL: pop -> ONE, main loads skid. Otherwise hold. push is impossible because in_ready=0.
- Derived outputs:
  - out_valid=1 in ONE and FULL.
  - in_ready is registered: 1 in EMPTY and ONE, 0 in FULL. It updates on the same edge as the state.
- Latency: 1 cycle from push into EMPTY to out_valid.
- Throughput: 1 transfer per cycle when out_ready is held high.
- Stability: while out_valid & !out_ready, every out_* port holds its value.
- Ordering: strict FIFO; no entry is dropped or duplicated.
- xfer_count increments by 1 on every pop and wraps from all-ones to 0.
- A push in the same cycle as reset deassertion takes effect only on the first clock edge after rstb is high.
- out_zero compares all WIDTH bits; out_negative is the raw MSB regardless of in_sel.

Test Plan:
- Reset: assert rstb=0 mid-stream with FULL state -> immediately out_valid=0, in_ready=1, out_result=0, xfer_count=0.
- Single pass-through: push in_result=32'h0000_0000, in_sel=3'd5, carry=1, out_ready=1 -> next cycle out_valid=1, out_zero=1, out_negative=0, out_sel=5, out_carry=1; one cycle later out_valid=0, xfer_count=1.
- Backpressure: with out_ready=0, push 32'h8000_0001 then 32'h0000_0007 -> state FULL, in_ready=0, third in_valid held; outputs stay at 8000_0001 with out_negative=1. Raise out_ready -> outputs 8000_0001, 0000_0007, then the third value, in order; xfer_count=3.
- Streaming: in_valid=1 and out_ready=1 for 100 cycles with values 1..100 -> outputs 1..100 on consecutive cycles, no bubbles, in_ready never drops, xfer_count=100.
- Simultaneous push/pop in ONE: main holds 32'hA, push 32'hB with out_ready=1 -> next cycle out_result=B, state stays ONE.
- Counter wrap: COUNT_WIDTH=4, perform 17 transfers -> xfer_count=1.
